// File: rtl/ifm_line_buf.sv
// Three-bank IFM row buffer: a load FSM fills bank (row mod 3) from the DRAM stream, and the
// read path returns the above/centre/below window words. Define IFM_LB_ZERO_PAD_EN for edge zero padding.
module ifm_line_buf #(
  parameter int IFM_DW = 32,
  parameter int W_SIZE = 12,
  parameter int MAX_W  = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [W_SIZE-1:0] q_width,
  input  logic              c_ifm_buf_req_load,
  input  logic [W_SIZE-1:0] c_ifm_buf_req_row,
  input  logic              s_valid,
  input  logic [IFM_DW-1:0] s_data,
  output logic              s_ready,
  output logic              o_ifm_buf_done,
  output logic [2:0]        o_bank_valid,
  output logic              o_overrun,
  input  logic              c_ctrl_data_run,
  input  logic [W_SIZE-1:0] c_row,
  input  logic [W_SIZE-1:0] c_col,
  input  logic              c_is_first_row,
  input  logic              c_is_last_row,
  output logic [IFM_DW-1:0] ib_data0_in,
  output logic [IFM_DW-1:0] ib_data1_in,
  output logic [IFM_DW-1:0] ib_data2_in,
  output logic [1:0]        dbg_state
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [W_SIZE:0] MAX_WL = (W_SIZE+1)'(MAX_W);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [W_SIZE-1:0] cnt;
  logic [1:0]        bank;
  logic [IFM_DW-1:0] mem [3][MAX_W];

  logic [W_SIZE:0]   eff_w;
  logic [1:0]        req_bank;
  logic              beat;
  logic              last_beat;
  logic [1:0]        rb0, rb1, rb2;
  logic [AW-1:0]     rd_addr;

  function automatic logic [1:0] mod3(input logic [W_SIZE-1:0] v);
    return 2'(v % W_SIZE'(3));
  endfunction

  // s_valid/s_ready: a beat transfers on any rising edge where both are high; s_ready is
  // high exactly while the FSM is in LOAD, so beats offered in other states stay pending.
  assign eff_w     = ({1'b0, q_width} > MAX_WL) ? MAX_WL : {1'b0, q_width};
  assign req_bank  = mod3(c_ifm_buf_req_row);
  assign beat      = (state == LOAD) && s_valid && s_ready;
  assign last_beat = (({1'b0, cnt} + 1'b1) >= eff_w);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      bank           <= '0;
      s_ready        <= 1'b0;
      o_ifm_buf_done <= 1'b0;
      o_overrun      <= 1'b0;
      o_bank_valid   <= 3'b000;
    end else begin
      o_ifm_buf_done <= 1'b0;
      if (c_ifm_buf_req_load && (state != IDLE))
        o_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (c_ifm_buf_req_load) begin
            bank <= req_bank;
            cnt  <= '0;
            if (eff_w == '0) begin
              // Empty row: nothing to stream, report completion straight away.
              state                  <= DONE;
              o_ifm_buf_done         <= 1'b1;
              o_bank_valid[req_bank] <= 1'b1;
            end else begin
              state                  <= LOAD;
              s_ready                <= 1'b1;
              o_bank_valid[req_bank] <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state              <= DONE;
              s_ready            <= 1'b0;
              o_ifm_buf_done     <= 1'b1;
              o_bank_valid[bank] <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat)
      mem[bank][cnt[AW-1:0]] <= s_data;
  end

  // Window banks: centre is c_row mod 3, above/below are its cyclic neighbours (row 0 -> above is bank 2).
  assign rb1     = mod3(c_row);
  assign rb0     = (rb1 == 2'd0) ? 2'd2 : rb1 - 2'd1;
  assign rb2     = (rb1 == 2'd2) ? 2'd0 : rb1 + 2'd1;
  assign rd_addr = c_col[AW-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ib_data0_in <= '0;
      ib_data1_in <= '0;
      ib_data2_in <= '0;
    end else if (c_ctrl_data_run) begin
`ifdef IFM_LB_ZERO_PAD_EN
      ib_data0_in <= c_is_first_row ? '0 : mem[rb0][rd_addr];
      ib_data2_in <= c_is_last_row  ? '0 : mem[rb2][rd_addr];
`else
      ib_data0_in <= mem[rb0][rd_addr];
      ib_data2_in <= mem[rb2][rd_addr];
`endif
      ib_data1_in <= mem[rb1][rd_addr];
    end
  end

`ifdef IFM_LB_ZERO_PAD_EN
  logic unused_in;
  assign unused_in = ^c_col;
`else
  logic unused_in;
  assign unused_in = ^{c_col, c_is_first_row, c_is_last_row};
`endif

endmodule

// File: tb/tb_ifm_line_buf.sv
// Self-checking bench for ifm_line_buf: row loads, stalls, window reads, read-during-write,
// empty rows, overrun and reset mid-load. Expected read data comes from a bench-side bank model.
module tb_ifm_line_buf;

  localparam int DW = 32;
  localparam int WS = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic [WS-1:0] q_width;
  logic          c_ifm_buf_req_load;
  logic [WS-1:0] c_ifm_buf_req_row;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          o_ifm_buf_done;
  logic [2:0]    o_bank_valid;
  logic          o_overrun;
  logic          c_ctrl_data_run;
  logic [WS-1:0] c_row;
  logic [WS-1:0] c_col;
  logic          c_is_first_row;
  logic          c_is_last_row;
  logic [DW-1:0] ib_data0_in;
  logic [DW-1:0] ib_data1_in;
  logic [DW-1:0] ib_data2_in;
  logic [1:0]    dbg_state;

  ifm_line_buf #(.IFM_DW(DW), .W_SIZE(WS), .MAX_W(256)) dut (
    .clk(clk), .rstn(rstn), .q_width(q_width),
    .c_ifm_buf_req_load(c_ifm_buf_req_load), .c_ifm_buf_req_row(c_ifm_buf_req_row),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_ifm_buf_done(o_ifm_buf_done), .o_bank_valid(o_bank_valid), .o_overrun(o_overrun),
    .c_ctrl_data_run(c_ctrl_data_run), .c_row(c_row), .c_col(c_col),
    .c_is_first_row(c_is_first_row), .c_is_last_row(c_is_last_row),
    .ib_data0_in(ib_data0_in), .ib_data1_in(ib_data1_in), .ib_data2_in(ib_data2_in),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [DW-1:0]   model [3][256];
  logic [3*DW-1:0] exp_q [$];
  logic [3*DW-1:0] last_exp;

  always @(negedge clk) if (o_ifm_buf_done === 1'b1) done_cnt++;

  function automatic logic [DW-1:0] word_of(input int row, input int w);
    logic [31:0] r;
    logic [31:0] c;
    if (w == 0 && row == 0) return 32'h00707064;
    if (w == 0 && row == 1) return 32'h00474644;
    if (w == 0 && row == 2) return 32'h003C3C3A;
    r = row;
    c = w;
    return (r * 32'h01000193) ^ (c * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [3*DW-1:0] window_of(input int row, input int col);
    return {model[(row + 2) % 3][col], model[row % 3][col], model[(row + 1) % 3][col]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input int row);
    @(negedge clk);
    c_ifm_buf_req_load = 1'b1;
    c_ifm_buf_req_row  = WS'(row);
    @(negedge clk);
    c_ifm_buf_req_load = 1'b0;
  endtask

  // Offers words [first, first+n) of a row; ends on the negedge right after the last accepted beat.
  task automatic stream(input int row, input int first, input int n,
                        input int stall_at, input int stall_len);
    int w = first;
    int stall_rem = stall_len;
    int budget = n * 4 + 20;
    while (w < first + n && budget > 0) begin
      checks++;
      if (o_ifm_buf_done !== 1'b0) begin
        errors++;
        $display("FAIL early_done: done=%b at word %0d, required 0", o_ifm_buf_done, w);
      end
      if (w == stall_at && stall_rem > 0) begin
        s_valid = 1'b0;
        stall_rem--;
      end else if (s_ready === 1'b1) begin
        s_valid = 1'b1;
        s_data  = word_of(row, w);
        model[row % 3][w] = s_data;
        w++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    s_valid = 1'b0;
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL stream_timeout: sent %0d words, required %0d", w - first, n);
    end
  endtask

  task automatic do_load(input int row, input int stall_at, input int stall_len,
                         input logic [2:0] exp_valid);
    int d0;
    d0 = done_cnt;
    send_req(row);
    stream(row, 0, 16, stall_at, stall_len);
    checks += 3;
    if (o_ifm_buf_done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse row%0d: done=%b, required 1", row, o_ifm_buf_done);
    end
    if (o_bank_valid !== exp_valid) begin
      errors++;
      $display("FAIL bank_valid row%0d: got %b, required %b", row, o_bank_valid, exp_valid);
    end
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL s_ready_after row%0d: got %b, required 0", row, s_ready);
    end
    @(negedge clk);
    checks += 2;
    if (o_ifm_buf_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width row%0d: done=%b, required 0", row, o_ifm_buf_done);
    end
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL done_count row%0d: got %0d pulses, required 1", row, done_cnt - d0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, o_ifm_buf_done, o_overrun, o_bank_valid, dbg_state} !== 8'h00 ||
        {ib_data0_in, ib_data1_in, ib_data2_in} !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b done=%b ovr=%b valid=%b st=%0d ib=%h, required all 0",
               s_ready, o_ifm_buf_done, o_overrun, o_bank_valid, dbg_state,
               {ib_data0_in, ib_data1_in, ib_data2_in});
    end
    rstn = 1'b1;
    last_exp = '0;
    @(negedge clk);
  endtask

  task automatic test_loads;
    do_load(0, -1, 0, 3'b001);
    do_load(1, 8, 5, 3'b011);
    do_load(2, -1, 0, 3'b111);
  endtask

  task automatic run_reads(input int n, input bit fixed, input int frow, input int fcol);
    logic [3*DW-1:0] e;
    logic [3*DW-1:0] got;
    int row;
    int col;
    for (int i = 0; i <= n; i++) begin
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {ib_data0_in, ib_data1_in, ib_data2_in};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL read_data[%0d]: got %h, required %h", i, got, e);
        end
      end
      if (i < n) begin
        c_ctrl_data_run = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
        row = fixed ? frow : $urandom_range(0, 11);
        col = fixed ? fcol : $urandom_range(0, 15);
        c_row = WS'(row);
        c_col = WS'(col);
        c_is_first_row = fixed ? 1'b0 : 1'($urandom_range(0, 1));
        c_is_last_row  = fixed ? 1'b0 : 1'($urandom_range(0, 1));
        if (c_ctrl_data_run) begin
          last_exp = window_of(row, col);
`ifdef IFM_LB_ZERO_PAD_EN
          if (c_is_first_row) last_exp[3*DW-1:2*DW] = '0;
          if (c_is_last_row)  last_exp[DW-1:0] = '0;
`endif
        end
        exp_q.push_back(last_exp);
      end else begin
        c_ctrl_data_run = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_window;
    run_reads(1, 1'b1, 1, 0);
    checks++;
    if ({ib_data0_in, ib_data1_in, ib_data2_in} !== 96'h00707064_00474644_003C3C3A) begin
      errors++;
      $display("FAIL window_r1c0: got %h %h %h, required 00707064 00474644 003c3c3a",
               ib_data0_in, ib_data1_in, ib_data2_in);
    end
    run_reads(40, 1'b0, 0, 0);
  endtask

  // Reload row 3 into bank 0 while reading the very address being written each cycle.
  task automatic test_rdw;
    logic [3*DW-1:0] e;
    logic [3*DW-1:0] got;
    send_req(3);
    checks++;
    if (o_bank_valid !== 3'b110) begin
      errors++;
      $display("FAIL valid_clear: got %b, required 110", o_bank_valid);
    end
    for (int w = 0; w <= 16; w++) begin
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {ib_data0_in, ib_data1_in, ib_data2_in};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL rdw_data[%0d]: got %h, required %h", w, got, e);
        end
      end
      if (w < 16) begin
        if (s_ready !== 1'b1) begin
          errors++;
          $display("FAIL rdw_ready[%0d]: s_ready=%b, required 1", w, s_ready);
        end
        c_ctrl_data_run = 1'b1;
        c_row = WS'(1);
        c_col = WS'(w);
        c_is_first_row = 1'b0;
        c_is_last_row  = 1'b0;
        last_exp = window_of(1, w);
        exp_q.push_back(last_exp);
        s_valid = 1'b1;
        s_data  = word_of(3, w);
        model[0][w] = s_data;
      end else begin
        s_valid = 1'b0;
        c_ctrl_data_run = 1'b0;
        checks += 2;
        if (o_ifm_buf_done !== 1'b1) begin
          errors++;
          $display("FAIL rdw_done: done=%b, required 1", o_ifm_buf_done);
        end
        if (o_bank_valid !== 3'b111) begin
          errors++;
          $display("FAIL rdw_valid: got %b, required 111", o_bank_valid);
        end
      end
      @(negedge clk);
    end
    run_reads(8, 1'b0, 0, 0);
  endtask

  task automatic test_zero_width;
    q_width = '0;
    send_req(5);
    checks += 4;
    if (o_ifm_buf_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: done=%b, required 1", o_ifm_buf_done);
    end
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_ready: s_ready=%b, required 0", s_ready);
    end
    if (o_bank_valid !== 3'b111) begin
      errors++;
      $display("FAIL zero_valid: got %b, required 111", o_bank_valid);
    end
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL zero_overrun: got %b, required 0", o_overrun);
    end
    q_width = WS'(16);
    @(negedge clk);
  endtask

  task automatic test_overrun;
    int d0;
    d0 = done_cnt;
    send_req(4);
    stream(4, 0, 3, -1, 0);
    c_ifm_buf_req_load = 1'b1;
    c_ifm_buf_req_row  = WS'(7);
    s_valid = 1'b1;
    s_data  = word_of(4, 3);
    model[1][3] = s_data;
    @(negedge clk);
    c_ifm_buf_req_load = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", o_overrun);
    end
    stream(4, 4, 12, -1, 0);
    checks += 2;
    if (o_ifm_buf_done !== 1'b1) begin
      errors++;
      $display("FAIL overrun_done: done=%b, required 1", o_ifm_buf_done);
    end
    if (o_bank_valid !== 3'b111) begin
      errors++;
      $display("FAIL overrun_valid: got %b, required 111", o_bank_valid);
    end
    repeat (3) @(negedge clk);
    checks += 3;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d pulses, required 1", done_cnt - d0);
    end
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", o_overrun);
    end
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL overrun_idle: state=%0d, required 0", dbg_state);
    end
    run_reads(20, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_load;
    int d0;
    d0 = done_cnt;
    send_req(6);
    stream(6, 0, 8, -1, 0);
    rstn = 1'b0;
    #1;
    checks++;
    if ({s_ready, o_ifm_buf_done, o_overrun, o_bank_valid, dbg_state} !== 8'h00 ||
        {ib_data0_in, ib_data1_in, ib_data2_in} !== '0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b done=%b ovr=%b valid=%b st=%0d ib=%h, required all 0",
               s_ready, o_ifm_buf_done, o_overrun, o_bank_valid, dbg_state,
               {ib_data0_in, ib_data1_in, ib_data2_in});
    end
    last_exp = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    do_load(6, -1, 0, 3'b001);
  endtask

  task automatic test_back_to_back;
    do_load(7, 3, 2, 3'b011);
    do_load(8, -1, 0, 3'b111);
    run_reads(60, 1'b0, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    q_width            = WS'(16);
    c_ifm_buf_req_load = 1'b0;
    c_ifm_buf_req_row  = '0;
    s_valid            = 1'b0;
    s_data             = '0;
    c_ctrl_data_run    = 1'b0;
    c_row              = '0;
    c_col              = '0;
    c_is_first_row     = 1'b0;
    c_is_last_row      = 1'b0;
    last_exp           = '0;
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 256; a++)
        model[b][a] = '0;

    test_reset();
    test_loads();
    test_window();
    test_rdw();
    test_zero_width();
    test_overrun();
    test_reset_mid_load();
    test_back_to_back();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifm_line_buf.md
IFM_LINE_BUF -- requirements
Module: ifm_line_buf

Interface
REQ-001 SHALL have parameter IFM_DW, default 32, IFM word width.
REQ-002 SHALL have parameter W_SIZE, default 12, row/col/width field width.
REQ-003 SHALL have parameter MAX_W, default 256, words per bank.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port q_width, input, W_SIZE, words per row.
REQ-007 SHALL have ports c_ifm_buf_req_load, input, 1, load request pulse; and c_ifm_buf_req_row, input, W_SIZE, row to load.
REQ-008 SHALL have ports s_valid, input, 1; s_data, input, IFM_DW; s_ready, output, 1; this is the row-data stream from DRAM.
REQ-009 SHALL have port o_ifm_buf_done, output, 1, one-cycle pulse when a row load completes.
REQ-010 SHALL have port o_bank_valid, output, 3, per-bank loaded flag.
REQ-011 SHALL have port o_overrun, output, 1, sticky flag for a dropped request.
REQ-012 SHALL have ports c_ctrl_data_run, input, 1; c_row and c_col, input, W_SIZE; c_is_first_row and c_is_last_row, input, 1.
REQ-013 SHALL have ports ib_data0_in, ib_data1_in and ib_data2_in, output, IFM_DW each, the window rows above, centre and below, feeding pe_engine.

Function
REQ-014 SHALL hold three banks of MAX_W x IFM_DW words; row r maps to bank r mod 3.
REQ-015 SHALL run a load FSM with states IDLE, LOAD and DONE.
REQ-016 IDLE: on c_ifm_buf_req_load, SHALL latch bank = req_row mod 3, clear that bank's o_bank_valid bit, reset the word counter to 0, and go to LOAD.
REQ-017 LOAD: SHALL drive s_ready=1 and, on each s_valid&&s_ready, write s_data at counter address and increment the counter.
REQ-018 LOAD: after the write of word min(q_width,MAX_W)-1, SHALL go to DONE.
REQ-019 DONE: SHALL lasts one cycle, pulse o_ifm_buf_done=1, set the bank's o_bank_valid bit, and return to IDLE.
REQ-020 If q_width==0, SHALL go IDLE->DONE with no writes.
REQ-021 SHALL drive s_ready=0 outside LOAD; stream beats outside LOAD are not consumed.
REQ-022 A request arriving in LOAD or DONE SHALL be dropped and SHALL set o_overrun; o_overrun clears only on reset.
REQ-023 Read path: when c_ctrl_data_run=1, SHALL register ib_data0_in = bank[(c_row-1) mod 3][c_col], ib_data1_in = bank[c_row mod 3][c_col], ib_data2_in = bank[(c_row+1) mod 3][c_col]; latency is exactly 1 cycle.
REQ-024 When c_ctrl_data_run=0, SHALL hold ib_data*_in at their previous values.
REQ-025 On a same-cycle read and write of one bank address, SHALL return the pre-write contents.
REQ-026 A row-mod computation for c_row=0 SHALL treat (c_row-1) mod 3 as bank 2.

Reset
REQ-027 On rstn=0, SHALL set the FSM to IDLE, the counter to 0, s_ready, o_ifm_buf_done and o_overrun to 0, o_bank_valid to 3'b000, and ib_data*_in to 0, immediately (asynchronously).
REQ-028 Reset during LOAD SHALL abort the load with no done pulse; bank RAM contents are don't-care.

Configuration
REQ-029 SHALL define macro IFM_LB_ZERO_PAD_EN: when defined, ib_data0_in is registered as 0 when c_is_first_row=1 and ib_data2_in as 0 when c_is_last_row=1.
REQ-030 Without IFM_LB_ZERO_PAD_EN, SHALL output raw bank contents regardless of c_is_first_row and c_is_last_row, with padding left to the downstream stage.

Verification
REQ-031 Reset, then req row0 with q_width=16 and 16 beats (word0=0x00707064) -> o_ifm_buf_done pulses exactly once, one cycle after the 16th beat, and o_bank_valid=3'b001.
REQ-032 During a load, hold s_valid low for 5 cycles mid-row -> counter stalls, and done follows the final beat by 1 cycle with no lost words.
REQ-033 Load rows 0-2 (row1 word0=0x00474644), then data_run with c_row=1, c_col=0 -> next cycle gives ib0=0x00707064, ib1=0x00474644, ib2=0x003C3C3A.
REQ-034 With IFM_LB_ZERO_PAD_EN, c_row=0 and c_is_first_row=1 -> ib_data0_in=0; c_row=2 and c_is_last_row=1 -> ib_data2_in=0.
REQ-035 Issue a second req during LOAD -> o_overrun=1, and the first load completes normally.
REQ-036 Deassert rstn after 8 beats of LOAD -> all outputs return to 0, no done pulse occurs, and a fresh req reloads correctly.
